// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word and register-index widths plus the MEM/WB
// data-access FSM state encoding.
package cpu_types_pkg;

   localparam int WORD_W = 32;
   localparam int REG_W  = 5;

   typedef logic [WORD_W-1:0] word_t;
   typedef logic [REG_W-1:0]  regbits_t;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MEMWAIT = 1'b1
   } memwb_state_t;

endpackage

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with a two-state data-access FSM that stalls the
// pipeline on dcache misses and guards against double register writes.
module mem_wb_stage
   import cpu_types_pkg::*;
(
   input  logic     CLK,
   input  logic     nRST,
   input  logic     ihit,
   input  logic     dhit,
   input  word_t    dmemload,
   input  logic     flush,
   input  logic     mem_valid,
   input  logic     mem_dren,
   input  logic     mem_dwen,
   input  regbits_t mem_wreg,
   input  word_t    mem_npc,
   input  word_t    mem_extOut,
   input  logic     mem_jaltype,
   input  logic     mem_ldtype,
   input  logic     mem_PCSrc,
   input  logic     mem_Reg_Wen,
   input  logic     mem_jtype,
   input  logic     mem_immtype,
   input  logic     wbEN,
   output regbits_t wreg,
   output word_t    memReg,
   output word_t    npc,
   output word_t    extOut,
   output logic     jaltype,
   output logic     ldtype,
   output logic     PCSrc,
   output logic     Reg_Wen,
   output logic     jtype,
   output logic     immtype,
   output logic     wb_valid,
   output logic     mem_stall
);

   memwb_state_t state;
   word_t        ldbuf;
   logic         ld_done;
   logic         pflush;
   logic         req;
   logic         miss_start;
   logic         capture;
   logic         bubble;

   function automatic word_t load_select(input logic hit, input word_t rdata,
                                         input logic done, input word_t held);
      if (hit)
         return rdata;
      else if (done)
         return held;
      else
         return '0;
   endfunction

   assign req        = mem_valid & (mem_dren | mem_dwen);
   // ld_done keeps a completed miss from re-requesting while it waits for ihit
   assign miss_start = (state == IDLE) & req & ~dhit & ~ld_done;
   assign mem_stall  = nRST & ((state == MEMWAIT) | miss_start);
   assign capture    = ihit & ~mem_stall;
   assign bubble     = ~mem_valid | flush | pflush;

   // data-access FSM and load buffer
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state   <= IDLE;
         ldbuf   <= '0;
         ld_done <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (miss_start)
                  state <= MEMWAIT;
               if (capture)
                  ld_done <= 1'b0;
            end
            MEMWAIT: begin
               if (dhit) begin
                  state   <= IDLE;
                  ldbuf   <= dmemload;
                  ld_done <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // write-back bundle register
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         wreg     <= '0;
         memReg   <= '0;
         npc      <= '0;
         extOut   <= '0;
         jaltype  <= 1'b0;
         ldtype   <= 1'b0;
         PCSrc    <= 1'b0;
         Reg_Wen  <= 1'b0;
         jtype    <= 1'b0;
         immtype  <= 1'b0;
         wb_valid <= 1'b0;
         pflush   <= 1'b0;
      end else if (capture) begin
         wreg     <= mem_wreg;
         npc      <= mem_npc;
         extOut   <= mem_extOut;
         memReg   <= load_select(dhit, dmemload, ld_done, ldbuf);
         jaltype  <= mem_jaltype & ~bubble;
         ldtype   <= mem_ldtype  & ~bubble;
         PCSrc    <= mem_PCSrc   & ~bubble;
         Reg_Wen  <= mem_Reg_Wen & ~bubble;
         jtype    <= mem_jtype   & ~bubble;
         immtype  <= mem_immtype & ~bubble;
         wb_valid <= ~bubble;
         pflush   <= 1'b0;
      end else begin
         if (flush)
            pflush <= 1'b1;
         // the write-back stage already committed this instruction
         if (wbEN && wb_valid) begin
            Reg_Wen  <= 1'b0;
            wb_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios plus a random run
// against a transaction-level reference model.
module tb_mem_wb_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        ihit, dhit, flush, wbEN;
   logic [31:0] dmemload;
   logic        mem_valid, mem_dren, mem_dwen;
   logic [4:0]  mem_wreg;
   logic [31:0] mem_npc, mem_extOut;
   logic        mem_jaltype, mem_ldtype, mem_PCSrc, mem_Reg_Wen, mem_jtype, mem_immtype;
   logic [4:0]  wreg;
   logic [31:0] memReg, npc, extOut;
   logic        jaltype, ldtype, PCSrc, Reg_Wen, jtype, immtype, wb_valid, mem_stall;

   int total = 0;
   int bad   = 0;

   // reference model state
   bit          m_waiting, m_done, m_pflush;
   logic [31:0] m_buf;
   logic [4:0]  e_wreg;
   logic [31:0] e_memReg, e_npc, e_extOut;
   logic [5:0]  e_ctrl;
   logic        e_wb_valid;
   bit          e_data_known;

   mem_wb_stage dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemload(dmemload),
      .flush(flush), .mem_valid(mem_valid), .mem_dren(mem_dren), .mem_dwen(mem_dwen),
      .mem_wreg(mem_wreg), .mem_npc(mem_npc), .mem_extOut(mem_extOut),
      .mem_jaltype(mem_jaltype), .mem_ldtype(mem_ldtype), .mem_PCSrc(mem_PCSrc),
      .mem_Reg_Wen(mem_Reg_Wen), .mem_jtype(mem_jtype), .mem_immtype(mem_immtype),
      .wbEN(wbEN), .wreg(wreg), .memReg(memReg), .npc(npc), .extOut(extOut),
      .jaltype(jaltype), .ldtype(ldtype), .PCSrc(PCSrc), .Reg_Wen(Reg_Wen),
      .jtype(jtype), .immtype(immtype), .wb_valid(wb_valid), .mem_stall(mem_stall)
   );

   always #5 CLK = ~CLK;

   function automatic logic [5:0] dut_ctrl();
      return {jaltype, ldtype, PCSrc, Reg_Wen, jtype, immtype};
   endfunction

   function automatic logic [5:0] in_ctrl();
      return {mem_jaltype, mem_ldtype, mem_PCSrc, mem_Reg_Wen, mem_jtype, mem_immtype};
   endfunction

   // A data access stalls while outstanding, or when it is newly presented and misses.
   function automatic logic model_stall();
      return m_waiting || (mem_valid && (mem_dren || mem_dwen) && !dhit && !m_done);
   endfunction

   task automatic model_reset();
      m_waiting = 0; m_done = 0; m_pflush = 0; m_buf = '0;
      e_wreg = '0; e_memReg = '0; e_npc = '0; e_extOut = '0; e_ctrl = '0;
      e_wb_valid = 0; e_data_known = 1;
   endtask

   task automatic model_step();
      logic        st, cap, bub;
      logic [31:0] ld;
      st  = model_stall();
      cap = ihit && !st;
      bub = !mem_valid || flush || m_pflush;
      ld  = dhit ? dmemload : (m_done ? m_buf : 32'h0);
      if (m_waiting) begin
         if (dhit) begin m_waiting = 0; m_buf = dmemload; m_done = 1; end
      end else if (st) begin
         m_waiting = 1;
      end
      if (cap) begin
         e_ctrl = bub ? 6'h0 : in_ctrl();
         e_wb_valid = !bub;
         e_data_known = !bub;
         e_wreg = mem_wreg; e_npc = mem_npc; e_extOut = mem_extOut; e_memReg = ld;
         m_done = 0; m_pflush = 0;
      end else begin
         if (flush) m_pflush = 1;
         if (wbEN && e_wb_valid) begin e_ctrl[2] = 1'b0; e_wb_valid = 0; end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_idle();
      ihit = 0; dhit = 0; flush = 0; wbEN = 0; dmemload = '0;
      mem_valid = 0; mem_dren = 0; mem_dwen = 0; mem_wreg = '0;
      mem_npc = '0; mem_extOut = '0;
      {mem_jaltype, mem_ldtype, mem_PCSrc, mem_Reg_Wen, mem_jtype, mem_immtype} = '0;
   endtask

   task automatic test_reset();
      drive_idle();
      mem_valid = 1; mem_dren = 1;
      nRST = 0;
      model_reset();
      #12;
      total++;
      if ({wreg, memReg, npc, extOut, dut_ctrl(), wb_valid} !== '0) begin
         bad++; $display("FAIL reset_outputs: got %h want 0",
                         {wreg, memReg, npc, extOut, dut_ctrl(), wb_valid});
      end
      total++;
      if (mem_stall !== 1'b0) begin
         bad++; $display("FAIL reset_stall: got %b want 0", mem_stall);
      end
      @(posedge CLK); #1;
      nRST = 1;
      drive_idle();
   endtask

   task automatic test_load_hit();
      bit saw_stall = 0;
      drive_idle();
      mem_valid = 1; mem_dren = 1; dhit = 1; dmemload = 32'hDEADBEEF; ihit = 1;
      mem_wreg = 5'd5; mem_Reg_Wen = 1; mem_ldtype = 1; mem_npc = 32'h100;
      #1;
      if (mem_stall) saw_stall = 1;
      tick();
      if (mem_stall) saw_stall = 1;
      total++;
      if (memReg !== 32'hDEADBEEF || wreg !== 5'd5 || wb_valid !== 1'b1) begin
         bad++; $display("FAIL load_hit: memReg=%h wreg=%0d wb_valid=%b want deadbeef 5 1",
                         memReg, wreg, wb_valid);
      end
      total++;
      if (saw_stall) begin
         bad++; $display("FAIL load_hit_stall: stall seen=1 want 0");
      end
      total++;
      if (dut_ctrl() !== e_ctrl) begin
         bad++; $display("FAIL load_hit_ctrl: got %b want %b", dut_ctrl(), e_ctrl);
      end
      drive_idle();
      tick();
   endtask

   task automatic test_load_miss();
      drive_idle();
      mem_valid = 1; mem_dren = 1; ihit = 1; mem_wreg = 5'd9; mem_Reg_Wen = 1;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (mem_stall !== 1'b1) begin
            bad++; $display("FAIL load_miss_stall%0d: got %b want 1", i, mem_stall);
         end
         tick();
      end
      dhit = 1; dmemload = 32'h1234;
      tick();
      dhit = 0; dmemload = 32'hBAD0BAD0;
      #1;
      total++;
      if (mem_stall !== 1'b0) begin
         bad++; $display("FAIL load_miss_release: stall=%b want 0", mem_stall);
      end
      tick();
      total++;
      if (memReg !== 32'h1234 || wb_valid !== 1'b1 || wreg !== 5'd9) begin
         bad++; $display("FAIL load_miss_capture: memReg=%h wb_valid=%b wreg=%0d want 1234 1 9",
                         memReg, wb_valid, wreg);
      end
      drive_idle();
      tick();
   endtask

   task automatic test_flush_memwait();
      drive_idle();
      mem_valid = 1; mem_dren = 1; ihit = 1; mem_Reg_Wen = 1; mem_wreg = 5'd3;
      tick();
      flush = 1;
      tick();
      flush = 0;
      for (int i = 0; i < 2; i++) begin
         total++;
         if (mem_stall !== 1'b1) begin
            bad++; $display("FAIL flush_wait%0d: stall=%b want 1", i, mem_stall);
         end
         tick();
      end
      dhit = 1; dmemload = 32'h55AA;
      tick();
      dhit = 0;
      tick();
      total++;
      if (wb_valid !== 1'b0 || Reg_Wen !== 1'b0 || dut_ctrl() !== 6'h0) begin
         bad++; $display("FAIL flush_bubble: wb_valid=%b ctrl=%b want 0 0", wb_valid, dut_ctrl());
      end
      total++;
      if (memReg !== 32'h55AA) begin
         bad++; $display("FAIL flush_memreg: got %h want 55aa", memReg);
      end
      drive_idle();
      tick();
   endtask

   task automatic test_double_write();
      drive_idle();
      mem_valid = 1; ihit = 1; mem_Reg_Wen = 1; mem_wreg = 5'd17; mem_npc = 32'hABC0;
      mem_extOut = 32'h77; mem_immtype = 1;
      tick();
      drive_idle();
      wbEN = 1;
      tick();
      total++;
      if (Reg_Wen !== 1'b0 || wb_valid !== 1'b0) begin
         bad++; $display("FAIL dbl_write_clear: Reg_Wen=%b wb_valid=%b want 0 0", Reg_Wen, wb_valid);
      end
      total++;
      if (wreg !== 5'd17 || npc !== 32'hABC0 || extOut !== 32'h77 || immtype !== 1'b1) begin
         bad++; $display("FAIL dbl_write_hold: wreg=%0d npc=%h extOut=%h imm=%b want 17 abc0 77 1",
                         wreg, npc, extOut, immtype);
      end
      wbEN = 0;
   endtask

   task automatic test_async_reset();
      drive_idle();
      mem_valid = 1; ihit = 1; mem_Reg_Wen = 1; mem_wreg = 5'd8;
      tick();
      mem_dren = 1;
      tick();
      tick();
      #2;
      nRST = 0;
      #1;
      model_reset();
      total++;
      if ({wreg, memReg, npc, extOut, dut_ctrl(), wb_valid} !== '0 || mem_stall !== 1'b0) begin
         bad++; $display("FAIL async_reset: outputs=%h stall=%b want 0 0",
                         {wreg, memReg, npc, extOut, dut_ctrl(), wb_valid}, mem_stall);
      end
      @(posedge CLK); #1;
      nRST = 1;
      drive_idle();
      dhit = 1; dmemload = 32'hFFFF0000;
      tick();
      total++;
      if ({wreg, memReg, npc, extOut, dut_ctrl(), wb_valid} !== '0 || mem_stall !== 1'b0) begin
         bad++; $display("FAIL post_reset_dhit: outputs=%h stall=%b want 0 0",
                         {wreg, memReg, npc, extOut, dut_ctrl(), wb_valid}, mem_stall);
      end
      drive_idle();
   endtask

   task automatic test_random();
      for (int c = 0; c < 500; c++) begin
         ihit = ($urandom_range(0, 3) != 0);
         dhit = ($urandom_range(0, 9) < 4);
         dmemload = $urandom;
         flush = ($urandom_range(0, 9) == 0);
         wbEN = $urandom_range(0, 1);
         mem_valid = ($urandom_range(0, 4) != 0);
         mem_dren = $urandom_range(0, 1);
         mem_dwen = ($urandom_range(0, 4) == 0);
         mem_wreg = 5'($urandom);
         mem_npc = $urandom;
         mem_extOut = $urandom;
         {mem_jaltype, mem_ldtype, mem_PCSrc, mem_Reg_Wen, mem_jtype, mem_immtype} = 6'($urandom);
         #1;
         total++;
         if (mem_stall !== model_stall()) begin
            bad++; $display("FAIL rand_stall c%0d: got %b want %b", c, mem_stall, model_stall());
         end
         tick();
         total++;
         if (dut_ctrl() !== e_ctrl || wb_valid !== e_wb_valid) begin
            bad++; $display("FAIL rand_ctrl c%0d: ctrl=%b vld=%b want %b %b",
                            c, dut_ctrl(), wb_valid, e_ctrl, e_wb_valid);
         end
         if (e_data_known) begin
            total++;
            if ({wreg, memReg, npc, extOut} !== {e_wreg, e_memReg, e_npc, e_extOut}) begin
               bad++; $display("FAIL rand_data c%0d: got %h want %h", c,
                               {wreg, memReg, npc, extOut}, {e_wreg, e_memReg, e_npc, e_extOut});
            end
         end
      end
      drive_idle();
   endtask

   initial begin
      test_reset();
      test_load_hit();
      test_load_miss();
      test_flush_memwait();
      test_double_write();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL come from cpu_types_pkg (word_t 32 bits, regbits_t 5 bits).
REQ-002 CLK  in  1  single clock; all state SHALL update on the rising edge.
REQ-003 nRST  in  1  reset, asynchronous, active-low.
REQ-004 ihit  in  1  pipeline advance enable from the icache.
REQ-005 dhit  in  1  dcache completion for the current load or store.
REQ-006 dmemload  in  word_t  dcache read data, valid when dhit=1.
REQ-007 flush  in  1  squash request; the next captured instruction SHALL become a bubble.
REQ-008 mem_valid, mem_dren, mem_dwen  in  1 each  MEM-stage instruction valid, read request, write request.
REQ-009 mem_wreg  in  regbits_t; mem_npc, mem_extOut  in  word_t; mem_jaltype, mem_ldtype, mem_PCSrc, mem_Reg_Wen, mem_jtype, mem_immtype  in  1 each: MEM-stage fields.
REQ-010 wbEN  in  1  write-back commit pulse returned by the write-back stage.
REQ-011 wreg, memReg, npc, extOut, jaltype, ldtype, PCSrc, Reg_Wen, jtype, immtype  out: registered write-back bundle driving the write-back interface.
REQ-012 wb_valid  out  1  the bundle holds a live instruction.
REQ-013 mem_stall  out  1  freezes the upstream pipeline while a data access is outstanding.

Function
REQ-014 The FSM SHALL have states IDLE and MEMWAIT.
REQ-015 In IDLE, mem_valid=1, (mem_dren|mem_dwen)=1 and dhit=0 SHALL move the FSM to MEMWAIT on the next edge.
REQ-016 mem_stall SHALL be combinational: 1 in MEMWAIT, and 1 in IDLE under the REQ-015 condition; 0 otherwise.
REQ-017 In MEMWAIT, dhit=1 SHALL return the FSM to IDLE and latch dmemload into a load buffer.
REQ-018 Bundle capture SHALL occur on an edge with ihit=1 and mem_stall=0.
  - Latency is exactly one cycle from the MEM-stage fields to the outputs.
REQ-019 On capture, memReg SHALL take:
  - dmemload when dhit=1 in that cycle;
  - otherwise the load buffer when the access completed via MEMWAIT;
  - otherwise 0.
REQ-020 On capture with mem_valid=0, or with flush (or a pending flush) set, all control outputs SHALL be 0 and wb_valid SHALL be 0 (bubble).
REQ-021 flush asserted while no capture occurs SHALL set a pending-flush flag; the flag SHALL clear on the next capture.
REQ-022 flush SHALL NOT abort MEMWAIT; the FSM still waits for dhit.
REQ-023 Without capture, all outputs SHALL hold, except the REQ-024 case.
REQ-024 wbEN=1 with wb_valid=1 and no capture SHALL clear Reg_Wen and wb_valid on the next edge, preventing a double register write during a stall.
REQ-025 When wbEN and capture coincide, capture SHALL take priority.
REQ-026 wbEN with wb_valid=0 SHALL be ignored.

Reset
REQ-027 nRST=0 SHALL asynchronously force:
  - FSM to IDLE;
  - all outputs, the load buffer and pending-flush to 0;
  - mem_stall to 0.
REQ-028 Reset mid-MEMWAIT SHALL abandon the access; a dhit arriving after reset deasserts SHALL be ignored in IDLE unless a new request is present.

Structure
REQ-029 The FSM state enum (IDLE, MEMWAIT) SHALL be added to cpu_types_pkg; no other new package content.
REQ-030 The block SHALL be a single module with no sub-modules, and SHALL drive the write-back interface signals through its output ports.

Verification
REQ-031 Load hit: mem_dren=1, dhit=1, dmemload=0xDEADBEEF, ihit=1, mem_wreg=5 -> next cycle memReg=0xDEADBEEF, wreg=5, wb_valid=1, mem_stall never 1.
REQ-032 Load miss: dhit=0 for 3 cycles, then dhit=1 with dmemload=0x1234 -> mem_stall=1 for those 3 cycles and FSM in MEMWAIT; capture on the next ihit gives memReg=0x1234.
REQ-033 Flush during MEMWAIT: flush=1 at the second wait cycle -> FSM stays in MEMWAIT until dhit; the captured bundle has wb_valid=0 and Reg_Wen=0.
REQ-034 Double-write guard: wb_valid=1, Reg_Wen=1, wbEN=1, ihit=0 -> next cycle Reg_Wen=0, wb_valid=0, other fields held.
REQ-035 Async reset: nRST low mid-MEMWAIT between clock edges -> outputs 0 and mem_stall 0 immediately; a post-reset dhit=1 with mem_dren=0 causes no state change.
